// File: rtl/gcd_multi_pkg.sv
// Shared types and constants for the multi-algorithm GCD engine.
package gcd_multi_pkg;

    typedef enum logic [2:0] {
        IDLE_A,
        ACK_A,
        IDLE_B,
        CHECK,
        SHIFT,
        REDUCE,
        SUB,
        DONE
    } state_t;

    localparam int ALGO_SUB = 0;
    localparam int ALGO_BIN = 1;

    // Ceiling log2, usable in constant expressions for sizing registers.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/gcd_multi_step.sv
// Combinational single-step datapath: next (a, b, k) plus completion and result
// for whichever compute state the controller is currently in.
module gcd_multi_step
    import gcd_multi_pkg::*;
#(
    parameter int W   = 16,
    parameter int K_W = 5
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [K_W-1:0] k,
    input  state_t         state,
    output logic [W-1:0]   a_nxt,
    output logic [W-1:0]   b_nxt,
    output logic [K_W-1:0] k_nxt,
    output logic [W-1:0]   result_nxt,
    output logic           done,
    output logic           advance
);

    // One algorithm step selected by the current state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        a_nxt      = a;
        b_nxt      = b;
        k_nxt      = k;
        result_nxt = '0;
        done       = 1'b0;
        advance    = 1'b0;
        unique case (state)
            CHECK: begin
                // A zero operand short-circuits: gcd(x,0)=x, gcd(0,0)=0.
                if (a == '0 || b == '0) begin
                    done       = 1'b1;
                    result_nxt = a | b;
                end else begin
                    k_nxt = '0;
                end
            end
            SUB: begin
                if (a == b) begin
                    done       = 1'b1;
                    result_nxt = a;
                end else if (a > b) begin
                    a_nxt = a - b;
                end else begin
                    b_nxt = b - a;
                end
            end
            SHIFT: begin
                // Strip common factors of two, remembering how many in k.
                if (!a[0] && !b[0]) begin
                    a_nxt = a >> 1;
                    b_nxt = b >> 1;
                    k_nxt = k + K_W'(1);
                end else begin
                    advance = 1'b1;
                end
            end
            REDUCE: begin
                if (!a[0]) begin
                    a_nxt = a >> 1;
                end else if (!b[0]) begin
                    b_nxt = b >> 1;
                end else if (a == b) begin
                    done       = 1'b1;
                    result_nxt = a << k;
                end else if (a > b) begin
                    a_nxt = a - b;
                end else begin
                    b_nxt = b - a;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/gcd_multi.sv
// GCD engine with serial-operand four-phase req/ack handshake, selectable
// subtractive or binary algorithm, and a saturating compute-cycle counter.
module gcd_multi
    import gcd_multi_pkg::*;
#(
    parameter int W     = 16,
    parameter int ALGO  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [W-1:0]     AB,
    output logic             ack,
    output logic [W-1:0]     C,
    output logic             busy,
    output logic [CNT_W-1:0] cycles
);

    localparam int               K_W     = clog2(W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t         state, state_nxt;
    logic [W-1:0]   a, b, result;
    logic [K_W-1:0] k;

    logic [W-1:0]   a_step, b_step, result_step;
    logic [K_W-1:0] k_step;
    logic           step_done, step_advance;

    gcd_multi_step #(
        .W   (W),
        .K_W (K_W)
    ) u_step (
        .a          (a),
        .b          (b),
        .k          (k),
        .state      (state),
        .a_nxt      (a_step),
        .b_nxt      (b_step),
        .k_nxt      (k_step),
        .result_nxt (result_step),
        .done       (step_done),
        .advance    (step_advance)
    );

    // Next-state logic for the handshake and compute sequence.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE_A: if (req)  state_nxt = ACK_A;
            ACK_A:  if (!req) state_nxt = IDLE_B;
            IDLE_B: if (req)  state_nxt = CHECK;
            CHECK: begin
                if (step_done)            state_nxt = DONE;
                else if (ALGO == ALGO_BIN) state_nxt = SHIFT;
                else                      state_nxt = SUB;
            end
            SHIFT:  if (step_advance) state_nxt = REDUCE;
            REDUCE: if (step_done)    state_nxt = DONE;
            SUB:    if (step_done)    state_nxt = DONE;
            DONE:   if (!req)         state_nxt = IDLE_A;
            default: state_nxt = IDLE_A;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) state <= IDLE_A;
        else       state <= state_nxt;
    end

    // Operand capture, compute-step update and saturating cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            a      <= '0;
            b      <= '0;
            k      <= '0;
            result <= '0;
            cycles <= '0;
        end else begin
            unique case (state)
                IDLE_A: begin
                    if (req) begin
                        a      <= AB;
                        cycles <= '0;
                    end
                end
                IDLE_B: begin
                    if (req) b <= AB;
                end
                CHECK, SHIFT, REDUCE, SUB: begin
                    a <= a_step;
                    b <= b_step;
                    k <= k_step;
                    if (step_done) result <= result_step;
                    if (cycles != CNT_MAX) cycles <= cycles + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        ack  = (state == ACK_A) || (state == DONE);
        C    = (state == DONE) ? result : '0;
        busy = (state == CHECK) || (state == SHIFT) || (state == REDUCE) || (state == SUB);
    end

endmodule

// File: tb/tb_gcd_multi.sv
// Self-checking bench: four gcd_multi configurations against a modulo-based
// reference model, directed corner cases and randomized operand pairs.
module tb_gcd_multi;
    import gcd_multi_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  req_v;
    logic [3:0]  ack_v;
    logic [3:0]  busy_v;
    logic [31:0] ab_bus;

    logic [15:0] c_sub16, c_bin16, cyc_sub16, cyc_bin16, cyc_bin32;
    logic [7:0]  c_sub8, cyc_sub8;
    logic [31:0] c_bin32;

    int n_tests = 0;
    int n_fail  = 0;

    gcd_multi #(.W(16), .ALGO(0), .CNT_W(16)) u_sub16 (
        .clk(clk), .reset(reset), .req(req_v[0]), .AB(ab_bus[15:0]),
        .ack(ack_v[0]), .C(c_sub16), .busy(busy_v[0]), .cycles(cyc_sub16));
    gcd_multi #(.W(16), .ALGO(1), .CNT_W(16)) u_bin16 (
        .clk(clk), .reset(reset), .req(req_v[1]), .AB(ab_bus[15:0]),
        .ack(ack_v[1]), .C(c_bin16), .busy(busy_v[1]), .cycles(cyc_bin16));
    gcd_multi #(.W(8), .ALGO(0), .CNT_W(8)) u_sub8 (
        .clk(clk), .reset(reset), .req(req_v[2]), .AB(ab_bus[7:0]),
        .ack(ack_v[2]), .C(c_sub8), .busy(busy_v[2]), .cycles(cyc_sub8));
    gcd_multi #(.W(32), .ALGO(1), .CNT_W(16)) u_bin32 (
        .clk(clk), .reset(reset), .req(req_v[3]), .AB(ab_bus),
        .ack(ack_v[3]), .C(c_bin32), .busy(busy_v[3]), .cycles(cyc_bin32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_c(input int idx);
        case (idx)
            0: return 32'(c_sub16);
            1: return 32'(c_bin16);
            2: return 32'(c_sub8);
            default: return c_bin32;
        endcase
    endfunction

    function automatic logic [31:0] get_cyc(input int idx);
        case (idx)
            0: return 32'(cyc_sub16);
            1: return 32'(cyc_bin16);
            2: return 32'(cyc_sub8);
            default: return 32'(cyc_bin32);
        endcase
    endfunction

    // Reference gcd by the division form of Euclid.
    function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Subtractive cycles: one CHECK, then (sum of Euclid quotients - 1)
    // subtractions plus the final equality cycle.
    function automatic int ref_sub_cycles(input logic [31:0] x, input logic [31:0] y, input int cnt_w);
        longint total;
        logic [31:0] t;
        longint sat;
        sat = (longint'(1) << cnt_w) - 1;
        if (x == 0 || y == 0) return 1;
        total = 1;
        while (y != 0) begin
            total += longint'(x / y);
            t = x % y;
            x = y;
            y = t;
        end
        return int'((total > sat) ? sat : total);
    endfunction

    task automatic wait_ack(input int idx, input int limit, input string tag);
        int n;
        n = 0;
        while (ack_v[idx] !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(ack_v[idx]), 32'd1);
    endtask

    // Full two-operand transaction; exp_cyc < 0 skips the cycle-count check.
    task automatic run_op(input int idx, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_c, input int exp_cyc,
                          input bit early_drop, input string tag);
        @(negedge clk);
        ab_bus     = av;
        req_v[idx] = 1'b1;
        @(negedge clk);
        wait_ack(idx, 10, {tag, " A ack"});
        check({tag, " cycles cleared at A"}, get_cyc(idx), 32'd0);
        ab_bus = $urandom;
        @(negedge clk);
        check({tag, " A ack held"}, 32'(ack_v[idx]), 32'd1);
        req_v[idx] = 1'b0;
        @(negedge clk);
        check({tag, " A ack released"}, 32'(ack_v[idx]), 32'd0);
        ab_bus     = bv;
        req_v[idx] = 1'b1;
        @(negedge clk);
        ab_bus = $urandom;
        if (early_drop) req_v[idx] = 1'b0;
        wait_ack(idx, 2000, {tag, " result ack"});
        check({tag, " C"}, get_c(idx), exp_c);
        if (exp_cyc >= 0) check({tag, " cycles"}, get_cyc(idx), 32'(exp_cyc));
        check({tag, " busy in DONE"}, 32'(busy_v[idx]), 32'd0);
        if (early_drop) begin
            @(negedge clk);
            check({tag, " ack pulse"}, 32'(ack_v[idx]), 32'd0);
            check({tag, " C after pulse"}, get_c(idx), 32'd0);
        end else begin
            @(negedge clk);
            check({tag, " DONE hold"}, 32'(ack_v[idx]), 32'd1);
            req_v[idx] = 1'b0;
            @(negedge clk);
            check({tag, " ack drop"}, 32'(ack_v[idx]), 32'd0);
            check({tag, " C cleared"}, get_c(idx), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset  = 1'b1;
        req_v  = '0;
        ab_bus = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset ack %0d", i), 32'(ack_v[i]), 32'd0);
            check($sformatf("reset busy %0d", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("reset C %0d", i), get_c(i), 32'd0);
            check($sformatf("reset cycles %0d", i), get_cyc(i), 32'd0);
        end
        reset = 1'b0;

        // Directed cases.
        run_op(0, 12, 8, 4, 4, 1'b0, "sub16 12,8");
        run_op(1, 12, 8, 4, 8, 1'b0, "bin16 12,8");
        for (int idx = 0; idx < 2; idx++) begin
            run_op(idx, 0, 7, 7, 1, 1'b0, $sformatf("zero%0d 0,7", idx));
            run_op(idx, 9, 0, 9, 1, 1'b0, $sformatf("zero%0d 9,0", idx));
            run_op(idx, 0, 0, 0, 1, 1'b0, $sformatf("zero%0d 0,0", idx));
        end
        run_op(2, 255, 1, 1, ref_sub_cycles(255, 1, 8), 1'b0, "sub8 sat");
        run_op(3, 32'hFFFF_FFFE, 32'h8000_0000, 2, -1, 1'b0, "bin32 big");
        run_op(3, 35, 21, 7, 7, 1'b0, "bin32 35,21");

        // Reset in the middle of a long subtractive run.
        @(negedge clk);
        ab_bus   = 1000;
        req_v[0] = 1'b1;
        @(negedge clk);
        wait_ack(0, 10, "rst A ack");
        req_v[0] = 1'b0;
        @(negedge clk);
        ab_bus   = 3;
        req_v[0] = 1'b1;
        @(negedge clk);
        req_v[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("rst busy before", 32'(busy_v[0]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst ack", 32'(ack_v[0]), 32'd0);
        check("rst C", get_c(0), 32'd0);
        check("rst busy", 32'(busy_v[0]), 32'd0);
        check("rst cycles", get_cyc(0), 32'd0);
        check("rst state", 32'(u_sub16.state), 32'(IDLE_A));
        reset = 1'b0;
        run_op(0, 6, 4, 2, 4, 1'b1, "after rst 6,4");

        // Randomized operand pairs against the reference model.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            if (i % 7 == 3) ra = 0;
            run_op(0, ra, rb, ref_gcd(ra, rb), ref_sub_cycles(ra, rb, 16), i[0],
                   $sformatf("rnd sub %0d,%0d", ra, rb));
        end
        for (int i = 0; i < 20; i++) begin
            ra = 32'($urandom_range(1, 4095)) << $urandom_range(0, 4);
            rb = 32'($urandom_range(1, 4095)) << $urandom_range(0, 4);
            if (i % 9 == 4) rb = 0;
            run_op(1, ra, rb, ref_gcd(ra, rb), (rb == 0) ? 1 : -1, i[0],
                   $sformatf("rnd bin %0d,%0d", ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
